// File: rtl/johnson_decoder.sv
// Johnson code receiver: legality check, step-order tracking and binary phase decode with lock.
// Latency: every output is registered and appears 1 cycle after the in_valid sample.
// Backpressure: none. A sample is taken on every in_valid cycle; optional err_cnt under JOHNSON_DEC_ERRCNT_EN.
module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int IW       = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  jin,
    output logic [IW-1:0] idx,
    output logic          idx_valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked
`ifdef JOHNSON_DEC_ERRCNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);

    // PW holds values up to 2N; CW holds the step counter up to LOCK_CNT.
    localparam int PW = IW + 1;
    localparam int CW = $clog2(LOCK_CNT + 1);

    localparam logic [PW-1:0] TWO_N    = PW'(2 * N);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);
    localparam logic [CW-1:0] LOCK_VAL = CW'(LOCK_CNT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // The last legal index doubles as the visible idx: both update only on legal samples.
    logic [IW-1:0] idx_q, idx_d;
    logic          idx_valid_q, idx_valid_d;
    logic          illegal_q, illegal_d;
    logic          seq_err_q, seq_err_d;

    logic [PW-1:0] pop;
    logic [PW-1:0] n_trans;
    logic          legal;
    logic [IW-1:0] dec;
    logic [IW-1:0] succ_idx;
    logic          is_succ;
    logic          is_repeat;

    // Classify and decode the incoming code: a Johnson code has at most one bit transition.
    always_comb begin
        pop     = '0;
        n_trans = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + PW'(jin[i]);
        end
        for (int i = 0; i < N - 1; i++) begin
            n_trans = n_trans + PW'(jin[i] ^ jin[i+1]);
        end
        legal = (n_trans <= PW'(1));
        // Filling half counts ones upward; draining half (bit0 set) counts down from 2N.
        if (jin[0] == 1'b0) begin
            dec = IW'(pop);
        end else begin
            dec = IW'(TWO_N - pop);
        end
        succ_idx  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        is_succ   = (dec == succ_idx);
        is_repeat = (dec == idx_q);
    end

    // Lock FSM next-state and registered-pulse next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        idx_valid_d = 1'b0;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        if (in_valid) begin
            if (!legal) begin
                illegal_d = 1'b1;
                seq_err_d = (state_q == LOCKED);
                state_d   = UNLOCKED;
                cnt_d     = '0;
            end else begin
                idx_valid_d = 1'b1;
                idx_d       = dec;
                unique case (state_q)
                    UNLOCKED: begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                    end
                    ACQUIRE: begin
                        if (is_succ) begin
                            if (cnt_q + CW'(1) == LOCK_VAL) begin
                                state_d = LOCKED;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end else if (!is_repeat) begin
                            cnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_succ && !is_repeat) begin
                            seq_err_d = 1'b1;
                            state_d   = ACQUIRE;
                            cnt_d     = '0;
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset wins over any sample in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= UNLOCKED;
            cnt_q       <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
        end
    end

`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating error count; one increment per erroring sample even if both pulses fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if ((illegal_d || seq_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == LOCKED);

endmodule
